// File: rtl/bb8051_sfr_bank_pkg.sv
// Shared codes for the SFR bank: decoder action codes, timed-access keys and
// lock-state encodings, plus the width helper for the select/bit-index ports.
package bb8051_sfr_bank_pkg;

  typedef enum logic [1:0] {
    BB8051_SFR_ACT_NONE    = 2'd0,
    BB8051_SFR_ACT_RD      = 2'd1,
    BB8051_SFR_ACT_WR_BYTE = 2'd2,
    BB8051_SFR_ACT_WR_BIT  = 2'd3
  } sfr_act_e;

  localparam logic [7:0] BB8051_TA_KEY1 = 8'hAA;
  localparam logic [7:0] BB8051_TA_KEY2 = 8'h55;

  typedef enum logic [1:0] {
    BB8051_TA_LOCKED = 2'd0,
    BB8051_TA_ARMED  = 2'd1,
    BB8051_TA_OPEN   = 2'd2
  } ta_state_e;

  // One spare bit above $clog2(n) so out-of-range indices reach the bank and
  // are rejected there instead of aliasing onto a real register/bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) + 1 : 1;
  endfunction

endpackage

// File: rtl/bb8051_sfr_bank_if.sv
// CPU-side SFR bus between the address decoder (master) and the register bank (slave).
interface bb8051_sfr_bank_if
  import bb8051_sfr_bank_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 8
);
  localparam int SEL_W = idx_w(NUM_REGS);
  localparam int BIT_W = idx_w(DATA_W);

  sfr_act_e          sfr_action;
  logic [SEL_W-1:0]  reg_sel;
  logic [BIT_W-1:0]  bit_addr;
  logic              bit_data;
  logic [DATA_W-1:0] wr_data;
  logic              ta_wr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              wr_denied;

  modport master (
    output sfr_action, reg_sel, bit_addr, bit_data, wr_data, ta_wr,
    input  rd_data, rd_valid, wr_denied
  );

  modport slave (
    input  sfr_action, reg_sel, bit_addr, bit_data, wr_data, ta_wr,
    output rd_data, rd_valid, wr_denied
  );

endinterface

// File: rtl/bb8051_sfr_bank_ta_lock.sv
// Timed-access lock: AA then 55 on the TA SFR opens a short write window that
// closes on the first protected write, on timeout, or on any further TA write.
module bb8051_ta_lock
  import bb8051_sfr_bank_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int TA_WINDOW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ta_wr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              consume,
  output logic              wr_open
);
  localparam int CNT_W = $clog2(TA_WINDOW + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TA_WINDOW);

  ta_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key1, key2;

  assign key1    = (wr_data == DATA_W'(BB8051_TA_KEY1));
  assign key2    = (wr_data == DATA_W'(BB8051_TA_KEY2));
  assign wr_open = (state_q == BB8051_TA_OPEN);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= BB8051_TA_LOCKED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
    unique case (state_q)
      BB8051_TA_LOCKED: begin
        cnt_d = '0;
        if (ta_wr && key1) begin
          state_d = BB8051_TA_ARMED;
          cnt_d   = CNT_LOAD;
        end
      end
      // Expiry wins over a late key so the window is exactly TA_WINDOW cycles.
      BB8051_TA_ARMED: begin
        if (cnt_q == '0) begin
          state_d = BB8051_TA_LOCKED;
        end else if (ta_wr) begin
          state_d = key2 ? BB8051_TA_OPEN : BB8051_TA_LOCKED;
          cnt_d   = key2 ? CNT_LOAD : '0;
        end
      end
      BB8051_TA_OPEN: begin
        if (ta_wr) begin
          state_d = key1 ? BB8051_TA_ARMED : BB8051_TA_LOCKED;
          cnt_d   = key1 ? CNT_LOAD : '0;
        end else if (consume || cnt_q == '0) begin
          state_d = BB8051_TA_LOCKED;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = BB8051_TA_LOCKED;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/bb8051_sfr_bank.sv
// Bank of NUM_REGS bit-addressable SFRs: byte/bit writes, registered reads,
// per-bit hardware set/clear. Timed-access write lock under BB8051_SFR_TIMED_ACCESS_EN.
module bb8051_sfr_bank
  import bb8051_sfr_bank_pkg::*;
#(
  parameter int                            NUM_REGS  = 4,
  parameter int                            DATA_W    = 8,
  parameter logic [NUM_REGS*DATA_W-1:0]    RST_VAL   = '0,
  parameter logic [NUM_REGS-1:0]           PROT_MASK = '0,
  parameter int                            TA_WINDOW = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  bb8051_sfr_bank_if.slave           bus,
  input  logic [NUM_REGS*DATA_W-1:0] hw_set,
  input  logic [NUM_REGS*DATA_W-1:0] hw_clr,
  output logic [NUM_REGS*DATA_W-1:0] regs_out
);
  localparam int SEL_W = idx_w(NUM_REGS);
  localparam int BIT_W = idx_w(DATA_W);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d, set_v, clr_v, rst_v;
  logic [DATA_W-1:0] bit_mask, rd_mux, rd_data_q;
  logic is_byte, is_bit, sel_ok, bit_ok, wr_req, wr_allow, rd_valid_q;

  assign set_v    = hw_set;
  assign clr_v    = hw_clr;
  assign rst_v    = RST_VAL;
  assign regs_out = regs_q;

  assign is_byte  = (bus.sfr_action == BB8051_SFR_ACT_WR_BYTE);
  assign is_bit   = (bus.sfr_action == BB8051_SFR_ACT_WR_BIT);
  assign sel_ok   = (bus.reg_sel < SEL_W'(NUM_REGS));
  assign bit_ok   = (bus.bit_addr < BIT_W'(DATA_W));
  assign wr_req   = sel_ok && (is_byte || (is_bit && bit_ok));
  assign bit_mask = DATA_W'(1) << bus.bit_addr;

`ifdef BB8051_SFR_TIMED_ACCESS_EN
  logic prot_hit, wr_open, wr_denied_q;

  always_comb begin
    prot_hit = 1'b0;
    for (int i = 0; i < NUM_REGS; i++)
      if (bus.reg_sel == SEL_W'(i)) prot_hit = PROT_MASK[i];
  end

  bb8051_ta_lock #(
    .DATA_W    (DATA_W),
    .TA_WINDOW (TA_WINDOW)
  ) u_ta_lock (
    .clk     (clk),
    .rst     (rst),
    .ta_wr   (bus.ta_wr),
    .wr_data (bus.wr_data),
    .consume (wr_req && prot_hit && wr_open),
    .wr_open (wr_open)
  );

  assign wr_allow = !prot_hit || wr_open;

  always_ff @(posedge clk) begin
    if (!rst) wr_denied_q <= 1'b0;
    else      wr_denied_q <= wr_req && !wr_allow;
  end

  assign bus.wr_denied = wr_denied_q;
`else
  logic unused_ta;
  assign unused_ta     = bus.ta_wr;
  assign wr_allow      = 1'b1;
  assign bus.wr_denied = 1'b0;
`endif

  // CPU-written bits override the hw set/clr result; set beats clear.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    logic              hit;
    logic [DATA_W-1:0] cpu_mask, cpu_val, hw_nxt;

    assign hit      = wr_req && wr_allow && (bus.reg_sel == SEL_W'(g));
    assign cpu_mask = !hit ? '0 : (is_byte ? {DATA_W{1'b1}} : bit_mask);
    assign cpu_val  = is_byte ? bus.wr_data : {DATA_W{bus.bit_data}};
    assign hw_nxt   = (regs_q[g] | set_v[g]) & ~(clr_v[g] & ~set_v[g]);
    assign regs_d[g] = (cpu_val & cpu_mask) | (hw_nxt & ~cpu_mask);
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (bus.reg_sel == SEL_W'(i)) rd_mux = regs_q[i];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      regs_q     <= rst_v;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      rd_valid_q <= (bus.sfr_action == BB8051_SFR_ACT_RD);
      if (bus.sfr_action == BB8051_SFR_ACT_RD) rd_data_q <= rd_mux;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;

endmodule
